// File: rtl/output_display_pkg.sv
// Shared types, glyph/segment constants and BCD helpers for the output display.
package output_display_pkg;

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    localparam logic [3:0] DIG_BLANK  = 4'hA;
    localparam logic [3:0] DIG_MINUS  = 4'hB;
    localparam logic [6:0] SEG_BLANK  = 7'b0000000;
    localparam logic [6:0] SEG_MINUS  = 7'b1000000;
    localparam logic [6:0] SEG_ZERO   = 7'b0111111;
    localparam logic [3:0] SHIFT_LAST = 4'd8;

    localparam int DIG_ONES = 0;
    localparam int DIG_TENS = 1;
    localparam int DIG_HUND = 2;
    localparam int DIG_SIGN = 3;

    // 8'h80 in signed mode negates to 8'h80, which reads back as 128 unsigned.
    function automatic logic [7:0] magnitude(input logic [7:0] value, input logic is_signed);
        return (is_signed && value[7]) ? (~value + 8'd1) : value;
    endfunction

    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] r;
        r = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/output_display_seg7_decode.sv
// Glyph code to active-high {g,f,e,d,c,b,a} segment pattern.
module seg7_decode
    import output_display_pkg::*;
(
    input  logic [3:0] glyph,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            4'd0:      seg = SEG_ZERO;
            4'd1:      seg = 7'b0000110;
            4'd2:      seg = 7'b1011011;
            4'd3:      seg = 7'b1001111;
            4'd4:      seg = 7'b1100110;
            4'd5:      seg = 7'b1101101;
            4'd6:      seg = 7'b1111101;
            4'd7:      seg = 7'b0000111;
            4'd8:      seg = 7'b1111111;
            4'd9:      seg = 7'b1101111;
            DIG_MINUS: seg = SEG_MINUS;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/output_display.sv
// CPU output register consumer: latches a byte, converts to BCD by double-dabble,
// and scans it onto a 4-digit multiplexed 7-segment display.
//
//   state | meaning
//   IDLE  | display stable, waiting for load
//   CONV  | 8 shift-add-3 steps, then one completion edge (shift_cnt == 8)
module output_display
    import output_display_pkg::*;
#(
    parameter int SCAN_DIV      = 1024,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] data_in,
    input  logic       signed_mode,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] dig_sel
);

    localparam int             SCW       = $clog2(SCAN_DIV);
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    state_t         state, state_nxt;
    logic [3:0]     shift_cnt;
    logic [7:0]     mag;
    logic [11:0]    bcd;
    logic           conv_neg;
    logic           pend_valid, pend_signed;
    logic [7:0]     pend_data;
    logic [11:0]    disp_bcd, disp_bcd_nxt;
    logic           disp_neg, disp_neg_nxt;
    logic           done, start;
    logic [7:0]     src_data;
    logic           src_signed;
    logic [SCW-1:0] scan_cnt;
    logic           scan_wrap;
    logic [3:0]     dig_sel_nxt;
    logic [3:0]     glyph;
    logic [6:0]     seg_nxt;

    assign done  = (state == CONV) && (shift_cnt == SHIFT_LAST);
    assign start = (state == IDLE) ? load : (done && (load || pend_valid));
    // A load on the completion edge is newer than anything pending.
    assign src_data   = load ? data_in     : pend_data;
    assign src_signed = load ? signed_mode : pend_signed;

    always_ff @(posedge clk) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = CONV;
            CONV: if (done && !start) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONV);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            shift_cnt   <= '0;
            mag         <= '0;
            bcd         <= '0;
            conv_neg    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_data   <= '0;
            pend_signed <= 1'b0;
            disp_bcd    <= '0;
            disp_neg    <= 1'b0;
        end else begin
            if (start) begin
                {bcd, mag} <= {12'd0, magnitude(src_data, src_signed)};
                conv_neg   <= src_signed & src_data[7];
                shift_cnt  <= '0;
            end else if ((state == CONV) && !done) begin
                {bcd, mag} <= {bcd_adjust(bcd), mag} << 1;
                shift_cnt  <= shift_cnt + 4'd1;
            end
            if (done) begin
                pend_valid <= 1'b0;
            end else if (busy && load) begin
                pend_valid  <= 1'b1;
                pend_data   <= data_in;
                pend_signed <= signed_mode;
            end
            disp_bcd <= disp_bcd_nxt;
            disp_neg <= disp_neg_nxt;
        end
    end

    // seg is built from next-cycle display/digit values so it never lags dig_sel.
    assign disp_bcd_nxt = done ? bcd      : disp_bcd;
    assign disp_neg_nxt = done ? conv_neg : disp_neg;
    assign scan_wrap    = (scan_cnt == SCAN_LAST);
    assign dig_sel_nxt  = scan_wrap ? {dig_sel[2:0], dig_sel[3]} : dig_sel;

    always_comb begin
        glyph = disp_bcd_nxt[DIG_ONES*4 +: 4];
        if (dig_sel_nxt[DIG_SIGN])
            glyph = disp_neg_nxt ? DIG_MINUS : DIG_BLANK;
        else if (dig_sel_nxt[DIG_HUND])
            glyph = (BLANK_LEADING && (disp_bcd_nxt[11:8] == 4'd0)) ?
                    DIG_BLANK : disp_bcd_nxt[DIG_HUND*4 +: 4];
        else if (dig_sel_nxt[DIG_TENS])
            glyph = (BLANK_LEADING && (disp_bcd_nxt[11:4] == 8'd0)) ?
                    DIG_BLANK : disp_bcd_nxt[DIG_TENS*4 +: 4];
    end

    seg7_decode u_decode (
        .glyph (glyph),
        .seg   (seg_nxt)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            scan_cnt <= '0;
            dig_sel  <= 4'b0001;
            seg      <= SEG_ZERO;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SCW'(1);
            dig_sel  <= dig_sel_nxt;
            seg      <= seg_nxt;
        end
    end

endmodule
